// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets, source limit, CLAIM "none" code.
package irq_pkg;

  localparam int IRQ_NSRC_MAX = 6;

  // Word offsets, compared against addr[3:2]
  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_MASK    = 2'd1;
  localparam logic [1:0] IRQ_EDGE    = 2'd2;
  localparam logic [1:0] IRQ_CLAIM   = 2'd3;

  localparam logic [31:0] IRQ_CLAIM_NONE = 32'd0;

  function automatic logic [31:0] irq_claim_code(input logic hit, input logic [2:0] idx);
    return hit ? ({29'd0, idx} + 32'd1) : IRQ_CLAIM_NONE;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-bit sample stage (two flops when IRQ_SYNC_EN is defined, else one), delayed copy and rising-edge detect.
module irq_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] src,
  output logic [W-1:0] s,
  output logic [W-1:0] rise
);

  logic [W-1:0] s_d;

`ifdef IRQ_SYNC_EN
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      s    <= '0;
    end else begin
      meta <= src;
      s    <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= '0;
    end else begin
      s <= src;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d <= '0;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised sources -> pending (edge/level) -> mask -> registered hwint, bus-mapped.
// IRQ_SYNC_EN selects a two-flop synchroniser on the source inputs (one flop when undefined).
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            sel,
  input  logic [3:0]      addr,
  input  logic            we,
  input  logic            re,
  input  logic [3:0]      byteen,
  input  logic [31:0]     wdata,
  input  logic            req,
  output logic [31:0]     rdata,
  output logic [5:0]      hwint
);

  logic [NSRC-1:0] s;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edge_mode;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] claim_oh;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pending_nxt;
  logic [2:0]      claim_idx;
  logic            claim_hit;
  logic            wr_en;
  logic            claim_en;
  logic [IRQ_NSRC_MAX-1:0] active_ext;
  logic            unused_bits;

  irq_sync #(.W(NSRC)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .src  (src),
    .s    (s),
    .rise (rise)
  );

  assign active   = pending & mask;
  assign wr_en    = sel & we & byteen[0] & ~req;
  assign claim_en = sel & re & ~req & (addr[3:2] == IRQ_CLAIM);

  // Fixed priority: scan downward so the lowest active index is the last one kept.
  always_comb begin
    claim_hit = 1'b0;
    claim_idx = 3'd0;
    claim_oh  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_hit   = 1'b1;
        claim_idx   = 3'(i);
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (wr_en && addr[3:2] == IRQ_PENDING) begin
      clr = wdata[NSRC-1:0];
    end
    if (claim_en) begin
      clr = clr | claim_oh;
    end
  end

  // Edge sources: a new rising edge beats any clear; level sources simply follow s.
  assign pending_nxt = (edge_mode & ((pending & ~clr) | rise)) | (~edge_mode & s);

  always_comb begin
    active_ext = '0;
    active_ext[NSRC-1:0] = active;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '0;
      hwint     <= '0;
    end else begin
      pending <= pending_nxt;
      hwint   <= active_ext;
      if (wr_en && addr[3:2] == IRQ_MASK) begin
        mask <= wdata[NSRC-1:0];
      end
      if (wr_en && addr[3:2] == IRQ_EDGE) begin
        edge_mode <= wdata[NSRC-1:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        IRQ_PENDING: rdata = {{(32-NSRC){1'b0}}, pending};
        IRQ_MASK:    rdata = {{(32-NSRC){1'b0}}, mask};
        IRQ_EDGE:    rdata = {{(32-NSRC){1'b0}}, edge_mode};
        IRQ_CLAIM:   rdata = irq_claim_code(claim_hit, claim_idx);
        default:     rdata = '0;
      endcase
    end
  end

  assign unused_bits = ^{addr[1:0], byteen[3:1], wdata[31:NSRC]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations queued with each stimulus and drained per scenario.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  src = '0;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  byteen = '0;
  logic [31:0] wdata = '0;
  logic        req = 1'b0;
  logic [31:0] rdata;
  logic [5:0]  hwint;

`ifdef IRQ_SYNC_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  localparam logic [3:0] A_PEND  = 4'h0;
  localparam logic [3:0] A_MASK  = 4'h4;
  localparam logic [3:0] A_EDGE  = 4'h8;
  localparam logic [3:0] A_CLAIM = 4'hC;

  int vectors = 0;
  int miscompares = 0;

  string       name_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  irq_ctrl #(.NSRC(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .src    (src),
    .sel    (sel),
    .addr   (addr),
    .we     (we),
    .re     (re),
    .byteen (byteen),
    .wdata  (wdata),
    .req    (req),
    .rdata  (rdata),
    .hwint  (hwint)
  );

  always #5 clk = ~clk;

  task automatic observe(input string nm, input logic [31:0] got, input logic [31:0] exp);
    name_q.push_back(nm);
    got_q.push_back(got);
    exp_q.push_back(exp);
  endtask

  // Called just after a negedge; holds the strobe across one rising edge.
  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    sel = 1'b1; re = 1'b1; addr = a;
    #1;
    observe(nm, rdata, exp);
    @(negedge clk);
    sel = 1'b0; re = 1'b0; addr = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d; byteen = be;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; byteen = '0;
  endtask

  task automatic test_reset();
    string nm; logic [31:0] e, g;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    observe("hwint_in_reset", {26'd0, hwint}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    bus_read(A_PEND,  32'h0, "rst_pending");
    bus_read(A_MASK,  32'h0, "rst_mask");
    bus_read(A_EDGE,  32'h0, "rst_edge");
    bus_read(A_CLAIM, 32'h0, "rst_claim");
    observe("rst_hwint", {26'd0, hwint}, 32'h0);
    while (exp_q.size() > 0) begin
      nm = name_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e);
      end
    end
  endtask

  task automatic test_edge_latency();
    string nm; logic [31:0] e, g;
    bus_write(A_MASK, 32'h3F, 4'b0001);
    bus_write(A_EDGE, 32'h01, 4'b0001);
    src[0] = 1'b1;
    for (int k = 0; k <= 2 + EXTRA; k++) begin
      @(negedge clk);
      if (k == 0) src[0] = 1'b0;
      observe($sformatf("edge_lat_k%0d", k), {31'd0, hwint[0]}, (k >= 2 + EXTRA) ? 32'd1 : 32'd0);
    end
    bus_read(A_PEND,  32'h1, "edge_pending");
    bus_read(A_CLAIM, 32'h1, "edge_claim");
    observe("claim_hwint_n1", {26'd0, hwint}, 32'h01);
    @(negedge clk);
    observe("claim_hwint_n2", {26'd0, hwint}, 32'h00);
    bus_read(A_PEND, 32'h0, "edge_pending_cleared");
    while (exp_q.size() > 0) begin
      nm = name_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e);
      end
    end
  endtask

  task automatic test_level();
    string nm; logic [31:0] e, g;
    bus_write(A_MASK, 32'h14, 4'b0001);
    src[2] = 1'b1; src[4] = 1'b1;
    repeat (3 + EXTRA) @(negedge clk);
    bus_read(A_CLAIM, 32'd3, "level_claim");
    bus_write(A_PEND, 32'h04, 4'b0001);
    bus_read(A_PEND, 32'h14, "level_w1c_no_effect");
    observe("level_hwint", {26'd0, hwint}, 32'h14);
    while (exp_q.size() > 0) begin
      nm = name_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    string nm; logic [31:0] e, g;
    rst = 1'b0;
    #1;
    observe("midrst_hwint", {26'd0, hwint}, 32'h0);
    sel = 1'b1; addr = A_PEND;
    #1;
    observe("midrst_pending", rdata, 32'h0);
    sel = 1'b0; addr = '0;
    @(negedge clk);
    src = '0;
    rst = 1'b1;
    @(negedge clk);
    bus_read(A_MASK, 32'h0, "midrst_mask");
    while (exp_q.size() > 0) begin
      nm = name_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e);
      end
    end
  endtask

  task automatic test_set_wins();
    string nm; logic [31:0] e, g;
    bus_write(A_MASK, 32'h3F, 4'b0001);
    bus_write(A_EDGE, 32'h02, 4'b0001);
    src[1] = 1'b1;
    repeat (1 + EXTRA) @(negedge clk);
    bus_write(A_PEND, 32'h02, 4'b0001);
    bus_read(A_PEND, 32'h02, "set_beats_w1c");
    observe("set_wins_hwint", {26'd0, hwint}, 32'h02);
    while (exp_q.size() > 0) begin
      nm = name_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e);
      end
    end
  endtask

  task automatic test_req_and_byteen();
    string nm; logic [31:0] e, g;
    req = 1'b1;
    bus_read(A_CLAIM, 32'd2, "req_claim_rdata");
    bus_write(A_MASK, 32'h00, 4'b0001);
    req = 1'b0;
    bus_read(A_PEND, 32'h02, "req_pending_kept");
    bus_read(A_MASK, 32'h3F, "req_mask_kept");
    bus_write(A_MASK, 32'h00, 4'b1110);
    bus_read(A_MASK, 32'h3F, "byteen_dropped");
    bus_write(A_PEND, 32'h02, 4'b0001);
    bus_read(A_PEND,  32'h00, "w1c_clears_edge");
    bus_read(A_CLAIM, 32'h00, "claim_none");
    sel = 1'b0; addr = A_MASK;
    #1;
    observe("unselected_rdata", rdata, 32'h0);
    addr = '0;
    src = '0;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      nm = name_q.pop_front(); e = exp_q.pop_front(); g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_level();
    test_reset_mid();
    test_set_wins();
    test_req_and_byteen();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
